// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM pipeline encodings, field widths and control-group type
//
// Purpose : ALU command encodings, register-index and immediate field widths,
//           and the packed control-bit group carried between pipeline stages.
// Ports   : none (package).
package arm_pkg;

    localparam int ALU_CMD_W  = 4;
    localparam int REG_IDX_W  = 4;
    localparam int SHIFT_OP_W = 12;
    localparam int IMM24_W    = 24;

    typedef logic [ALU_CMD_W-1:0] alu_cmd_t;

    localparam alu_cmd_t ALU_MOV = 4'b0001;
    localparam alu_cmd_t ALU_MVN = 4'b1001;
    localparam alu_cmd_t ALU_ADD = 4'b0010;
    localparam alu_cmd_t ALU_ADC = 4'b0011;
    localparam alu_cmd_t ALU_SUB = 4'b0100;
    localparam alu_cmd_t ALU_SBC = 4'b0101;
    localparam alu_cmd_t ALU_AND = 4'b0110;
    localparam alu_cmd_t ALU_ORR = 4'b0111;
    localparam alu_cmd_t ALU_EOR = 4'b1000;

    // Control bits that must be zero for a bubble; valid is the MSB.
    typedef struct packed {
        logic valid;
        logic wb_en;
        logic mem_read;
        logic mem_write;
        logic b;
        logic s;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // A non-valid slot carries no control effect at all.
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic keep);
        ctrl_t r;
        r = keep ? c : '0;
        return r;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - generic pipeline register with async reset, enable and synchronous clear
//
// Purpose : one field group of a pipeline stage register.
// Ports   : clk   - clock, rising edge
//           rst   - asynchronous active-high reset, clears q
//           en    - load d on the next edge
//           clr   - load zero on the next edge, overrides en
//           d / q - data in / registered data out (WIDTH bits)
module pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with stall, flush and bubble counter
//
// Purpose : carries a decoded instruction from ID into EXE. freeze holds the
//           stage, flush squashes the incoming instruction (flush wins over
//           freeze), valid_in=0 inserts a bubble. bubble_cnt counts, with
//           saturation, every load that leaves EXE holding a bubble.
// Ports   : clk, rst (async active-high)
//           freeze, flush                     - stage control
//           valid_in, wb_en_in, mem_read_in, mem_write_in, b_in, s_in
//                                             - control bits in
//           alu_command_in, pc_in, val_rn_in, val_rm_in, imm_in,
//           shift_operand_in, signed_imm_24_in, dest_in, src1_in, src2_in,
//           carry_in                          - datapath fields in
//           *_out                             - registered counterparts
//           bubble_cnt                        - saturating bubble count
module id_ex_stage_reg
    import arm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic                  wb_en_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  logic [ALU_CMD_W-1:0]  alu_command_in,
    input  logic [WIDTH-1:0]      pc_in,
    input  logic [WIDTH-1:0]      val_rn_in,
    input  logic [WIDTH-1:0]      val_rm_in,
    input  logic                  imm_in,
    input  logic [SHIFT_OP_W-1:0] shift_operand_in,
    input  logic [IMM24_W-1:0]    signed_imm_24_in,
    input  logic [REG_IDX_W-1:0]  dest_in,
    input  logic [REG_IDX_W-1:0]  src1_in,
    input  logic [REG_IDX_W-1:0]  src2_in,
    input  logic                  carry_in,
    output logic                  valid_out,
    output logic                  wb_en_out,
    output logic                  mem_read_out,
    output logic                  mem_write_out,
    output logic                  b_out,
    output logic                  s_out,
    output logic [ALU_CMD_W-1:0]  alu_command_out,
    output logic [WIDTH-1:0]      pc_out,
    output logic [WIDTH-1:0]      val_rn_out,
    output logic [WIDTH-1:0]      val_rm_out,
    output logic                  imm_out,
    output logic [SHIFT_OP_W-1:0] shift_operand_out,
    output logic [IMM24_W-1:0]    signed_imm_24_out,
    output logic [REG_IDX_W-1:0]  dest_out,
    output logic [REG_IDX_W-1:0]  src1_out,
    output logic [REG_IDX_W-1:0]  src2_out,
    output logic                  carry_out,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam int DP_W = ALU_CMD_W + 3 * WIDTH + 1 + SHIFT_OP_W + IMM24_W
                        + 3 * REG_IDX_W + 1;

    logic            load;
    logic            bubble;
    ctrl_t           ctrl_raw;
    ctrl_t           ctrl_d;
    ctrl_t           ctrl_q;
    logic [DP_W-1:0] dp_d;
    logic [DP_W-1:0] dp_q;
    logic [CNT_W-1:0] cnt_q;

    // flush forces a load even while frozen so the squash always lands.
    assign load   = ~freeze | flush;
    assign bubble = load & (flush | ~valid_in);

    assign ctrl_raw = '{valid:     valid_in,
                        wb_en:     wb_en_in,
                        mem_read:  mem_read_in,
                        mem_write: mem_write_in,
                        b:         b_in,
                        s:         s_in};
    assign ctrl_d   = gate_ctrl(ctrl_raw, valid_in);

    pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .en  (load),
        .clr (flush),
        .d   (ctrl_d),
        .q   (ctrl_q)
    );

    // Datapath fields keep loading on flush; they are meaningless once
    // valid_out is low, so no clear is needed here.
    assign dp_d = {alu_command_in, pc_in, val_rn_in, val_rm_in, imm_in,
                   shift_operand_in, signed_imm_24_in, dest_in, src1_in,
                   src2_in, carry_in};

    pipe_reg #(.WIDTH(DP_W)) u_dp_reg (
        .clk (clk),
        .rst (rst),
        .en  (load),
        .clr (1'b0),
        .d   (dp_d),
        .q   (dp_q)
    );

    assign {alu_command_out, pc_out, val_rn_out, val_rm_out, imm_out,
            shift_operand_out, signed_imm_24_out, dest_out, src1_out,
            src2_out, carry_out} = dp_q;

    // Side-effecting bits are gated by valid as a second line of defence.
    assign valid_out     = ctrl_q.valid;
    assign wb_en_out     = ctrl_q.wb_en & ctrl_q.valid;
    assign mem_read_out  = ctrl_q.mem_read;
    assign mem_write_out = ctrl_q.mem_write & ctrl_q.valid;
    assign b_out         = ctrl_q.b;
    assign s_out         = ctrl_q.s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - directed self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam int DP_W  = 150;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

    typedef struct packed {
        logic        v;
        logic        wb;
        logic        mr;
        logic        mw;
        logic        b;
        logic        s;
        logic [3:0]  alu;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  dest;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, flush;
    logic        valid_in, wb_en_in, mem_read_in, mem_write_in, b_in, s_in;
    logic [3:0]  alu_command_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic        imm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in, src1_in, src2_in;
    logic        carry_in;
    logic        valid_out, wb_en_out, mem_read_out, mem_write_out, b_out, s_out;
    logic [3:0]  alu_command_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic        imm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [3:0]  dest_out, src1_out, src2_out;
    logic        carry_out;
    logic [CNT_W-1:0] bubble_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_cnt;

    logic [5:0]      ctrl_act;
    logic [DP_W-1:0] dp_act;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .b_in(b_in), .s_in(s_in),
        .alu_command_in(alu_command_in), .pc_in(pc_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in),
        .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in),
        .src1_in(src1_in), .src2_in(src2_in), .carry_in(carry_in),
        .valid_out(valid_out), .wb_en_out(wb_en_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .b_out(b_out), .s_out(s_out), .alu_command_out(alu_command_out),
        .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .imm_out(imm_out), .shift_operand_out(shift_operand_out),
        .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out),
        .src1_out(src1_out), .src2_out(src2_out), .carry_out(carry_out),
        .bubble_cnt(bubble_cnt)
    );

    assign ctrl_act = {valid_out, wb_en_out, mem_read_out, mem_write_out, b_out, s_out};
    assign dp_act   = {alu_command_out, pc_out, val_rn_out, val_rm_out, imm_out,
                       shift_operand_out, signed_imm_24_out, dest_out, src1_out,
                       src2_out, carry_out};

    // Secondary fields are derived from the primary ones so every vector
    // exercises all datapath bits with values the bench already knows.
    task automatic drive(input vec_t t);
        valid_in         = t.v;
        wb_en_in         = t.wb;
        mem_read_in      = t.mr;
        mem_write_in     = t.mw;
        b_in             = t.b;
        s_in             = t.s;
        alu_command_in   = t.alu;
        pc_in            = t.pc;
        val_rn_in        = t.rn;
        val_rm_in        = t.rm;
        imm_in           = t.rn[0];
        shift_operand_in = t.rm[11:0];
        signed_imm_24_in = t.pc[25:2];
        dest_in          = t.dest;
        src1_in          = t.rn[3:0];
        src2_in          = t.rm[3:0];
        carry_in         = t.rm[31];
    endtask

    function automatic logic [DP_W-1:0] dp_exp(input vec_t t);
        return {t.alu, t.pc, t.rn, t.rm, t.rn[0], t.rm[11:0], t.pc[25:2],
                t.dest, t.rn[3:0], t.rm[3:0], t.rm[31]};
    endfunction

    function automatic logic [5:0] ctrl_exp(input vec_t t);
        return t.v ? {t.v, t.wb, t.mr, t.mw, t.b, t.s} : 6'b000000;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 4'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t v_add  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 32'h0000_0104, 32'd5, 32'd7, 4'd3};
    vec_t v_str  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 32'h0000_0200, 32'h0000_1000, 32'd8, 4'd2};
    vec_t v_ldr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 32'h0000_0300, 32'h0000_2000, 32'd4, 4'd5};
    vec_t v_eor  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 32'h0000_040C, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'hE};
    vec_t v_bub  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1001, 32'h0000_0408, 32'h0000_000A, 32'h0000_000B, 4'hF};

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        drive(v_add);
        #2;
        n_vec++; if (ctrl_act !== 6'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want %b", ctrl_act, 6'b0); end
        n_vec++; if (dp_act !== '0) begin n_err++; $display("FAIL reset_dp: got %h want 0", dp_act); end
        n_vec++; if (bubble_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt); end
        tick();
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_add();
        drive(v_add);
        tick();
        n_vec++; if (alu_command_out !== 4'b0010) begin n_err++; $display("FAIL add_alu: got %b want 0010", alu_command_out); end
        n_vec++; if (wb_en_out !== 1'b1) begin n_err++; $display("FAIL add_wb_en: got %b want 1", wb_en_out); end
        n_vec++; if (val_rn_out !== 32'd5) begin n_err++; $display("FAIL add_rn: got %0d want 5", val_rn_out); end
        n_vec++; if (val_rm_out !== 32'd7) begin n_err++; $display("FAIL add_rm: got %0d want 7", val_rm_out); end
        n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", valid_out); end
        n_vec++; if (dp_act !== dp_exp(v_add)) begin n_err++; $display("FAIL add_dp: got %h want %h", dp_act, dp_exp(v_add)); end
        n_vec++; if (bubble_cnt !== exp_cnt) begin n_err++; $display("FAIL add_cnt: got %0d want %0d", bubble_cnt, exp_cnt); end
    endtask

    task automatic test_freeze();
        vec_t seq [3];
        seq[0] = v_str; seq[1] = v_bub; seq[2] = v_eor;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(seq[i]);
            tick();
            n_vec++; if (ctrl_act !== ctrl_exp(v_add)) begin n_err++; $display("FAIL freeze_ctrl[%0d]: got %b want %b", i, ctrl_act, ctrl_exp(v_add)); end
            n_vec++; if (dp_act !== dp_exp(v_add)) begin n_err++; $display("FAIL freeze_dp[%0d]: got %h want %h", i, dp_act, dp_exp(v_add)); end
            n_vec++; if (bubble_cnt !== exp_cnt) begin n_err++; $display("FAIL freeze_cnt[%0d]: got %0d want %0d", i, bubble_cnt, exp_cnt); end
        end
        freeze = 1'b0;
    endtask

    task automatic test_flush();
        drive(v_str);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_cnt = cnt_inc(exp_cnt);
        n_vec++; if (mem_write_out !== 1'b0) begin n_err++; $display("FAIL flush_mem_write: got %b want 0", mem_write_out); end
        n_vec++; if (wb_en_out !== 1'b0) begin n_err++; $display("FAIL flush_wb_en: got %b want 0", wb_en_out); end
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", valid_out); end
        n_vec++; if (bubble_cnt !== exp_cnt) begin n_err++; $display("FAIL flush_cnt: got %0d want %0d", bubble_cnt, exp_cnt); end
        n_vec++; if (dp_act !== dp_exp(v_str)) begin n_err++; $display("FAIL flush_dp: got %h want %h", dp_act, dp_exp(v_str)); end
    endtask

    task automatic test_flush_freeze();
        drive(v_ldr);
        flush = 1'b1; freeze = 1'b1;
        tick();
        flush = 1'b0; freeze = 1'b0;
        exp_cnt = cnt_inc(exp_cnt);
        n_vec++; if (ctrl_act !== 6'b0) begin n_err++; $display("FAIL flfr_ctrl: got %b want 000000", ctrl_act); end
        n_vec++; if (bubble_cnt !== exp_cnt) begin n_err++; $display("FAIL flfr_cnt: got %0d want %0d", bubble_cnt, exp_cnt); end
        n_vec++; if (dp_act !== dp_exp(v_ldr)) begin n_err++; $display("FAIL flfr_dp: got %h want %h", dp_act, dp_exp(v_ldr)); end
    endtask

    task automatic test_back_to_back();
        vec_t tbl [5];
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h0000_0400, 32'h8000_0000, 32'h0000_0001, 4'd1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_0404, 32'h0000_0000, 32'hFFFF_FFFF, 4'd0};
        tbl[2] = v_bub;
        tbl[3] = v_ldr;
        tbl[4] = v_eor;
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i]);
            tick();
            if (!tbl[i].v) exp_cnt = cnt_inc(exp_cnt);
            n_vec++; if (ctrl_act !== ctrl_exp(tbl[i])) begin n_err++; $display("FAIL b2b_ctrl[%0d]: got %b want %b", i, ctrl_act, ctrl_exp(tbl[i])); end
            n_vec++; if (dp_act !== dp_exp(tbl[i])) begin n_err++; $display("FAIL b2b_dp[%0d]: got %h want %h", i, dp_act, dp_exp(tbl[i])); end
            n_vec++; if (bubble_cnt !== exp_cnt) begin n_err++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", i, bubble_cnt, exp_cnt); end
        end
    endtask

    task automatic test_async_reset();
        drive(v_add);
        tick();
        n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid: got %b want 1", valid_out); end
        #1 rst = 1'b1;
        #1;
        n_vec++; if (ctrl_act !== 6'b0) begin n_err++; $display("FAIL arst_ctrl: got %b want 000000", ctrl_act); end
        n_vec++; if (dp_act !== '0) begin n_err++; $display("FAIL arst_dp: got %h want 0", dp_act); end
        n_vec++; if (bubble_cnt !== 4'd0) begin n_err++; $display("FAIL arst_cnt: got %0d want 0", bubble_cnt); end
        #1 rst = 1'b0;
        exp_cnt = '0;
        drive(v_eor);
        tick();
        n_vec++; if (ctrl_act !== ctrl_exp(v_eor)) begin n_err++; $display("FAIL arst_post_ctrl: got %b want %b", ctrl_act, ctrl_exp(v_eor)); end
        n_vec++; if (dp_act !== dp_exp(v_eor)) begin n_err++; $display("FAIL arst_post_dp: got %h want %h", dp_act, dp_exp(v_eor)); end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] want;
        drive(v_bub);
        for (int i = 0; i < 20; i++) begin
            tick();
            want = (i + 1 >= 15) ? CNT_MAX : CNT_W'(i + 1);
            n_vec++; if (bubble_cnt !== want) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bubble_cnt, want); end
        end
        n_vec++; if (ctrl_act !== 6'b0) begin n_err++; $display("FAIL sat_ctrl: got %b want 000000", ctrl_act); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_freeze();
        test_flush();
        test_flush_freeze();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
